// File: rtl/square_share_arbiter.sv
// Round-robin front end for one shared unsigned squaring unit: grants one requester
// at a time, squares its captured operand and returns the result with its ID.
module square_share_arbiter #(
  parameter int SIZE = 4,
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] num_in,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ID_W-1:0]      out_id,
  output logic [2*SIZE-1:0]    out_sq
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [SIZE-1:0]   op_q, op_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic [2*SIZE-1:0] out_sq_q, out_sq_d;
  logic [2*SIZE-1:0] op_ext;

  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [SIZE-1:0]   win_op;
  logic              grant;
  int                idx;

  // Search order starts at the pointer and wraps; the first active request wins.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_op    = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
        win_op    = num_in[idx*SIZE +: SIZE];
      end
    end
  end

  assign op_ext = {{SIZE{1'b0}}, op_q};

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    op_d     = op_q;
    gnt_d    = '0;
    out_id_d = out_id_q;
    out_sq_d = out_sq_q;
    grant    = 1'b0;
    case (state_q)
      IDLE: grant = win_found;
      CALC: begin
        out_sq_d = op_ext * op_ext;
        out_id_d = id_q;
        state_d  = DONE;
      end
      DONE: if (out_ready) begin
        grant   = win_found;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A grant from IDLE or from the DONE handshake edge both go straight to CALC.
    if (grant) begin
      state_d = CALC;
      id_d    = win_id;
      op_d    = win_op;
      gnt_d   = NREQ'(1) << win_id;
      ptr_d   = (int'(win_id) == NREQ - 1) ? '0 : win_id + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      id_q     <= '0;
      op_q     <= '0;
      gnt_q    <= '0;
      out_id_q <= '0;
      out_sq_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      op_q     <= op_d;
      gnt_q    <= gnt_d;
      out_id_q <= out_id_d;
      out_sq_q <= out_sq_d;
    end
  end

  always_comb begin
    gnt       = gnt_q;
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
    out_id    = out_id_q;
    out_sq    = out_sq_q;
  end

endmodule

// File: tb/tb_square_share_arbiter.sv
// Directed bench for square_share_arbiter: hand-computed grants, squares, IDs,
// back-pressure, fairness and asynchronous reset behaviour.
module tb_square_share_arbiter;

  localparam int SIZE = 4;
  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*SIZE-1:0] num_in;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [ID_W-1:0]      out_id;
  logic [2*SIZE-1:0]    out_sq;

  int tests;
  int fails;

  square_share_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .num_in    (num_in),
    .gnt       (gnt),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_sq    (out_sq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input int id, input int sq);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".id"},    32'(out_id),    32'(id));
    check({tag, ".sq"},    32'(out_sq),    32'(sq));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".gnt"},  32'(gnt),  32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check_out(tag, 1'b0, 0, 0);
  endtask

  // Reset asserted between edges, held over one edge, released between edges.
  task automatic pulse_reset(input string tag);
    #1 rst_n = 1'b0;
    #1 check_zero(tag);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b1;
    req = '0;
    num_in = '0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #2 check_zero("reset");
    tick();
    rst_n = 1'b1;

    // Single request, operand F -> 225
    req = 4'b0001;
    num_in = 16'h000F;
    out_ready = 1'b1;
    tick();
    check("single.gnt", 32'(gnt), 32'h1);
    check("single.busy", 32'(busy), 32'd1);
    check("single.valid_early", 32'(out_valid), 32'd0);
    req = '0;
    tick();
    check("single.gnt_pulse", 32'(gnt), 32'd0);
    check_out("single", 1'b1, 0, 225);
    tick();
    check("single.idle_busy", 32'(busy), 32'd0);
    check_out("single.after", 1'b0, 0, 225);

    // All four at once from p=0: back-to-back grants 0,1,2,3
    pulse_reset("rst_a");
    req = 4'b1111;
    num_in = 16'h4321;
    out_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      tick();
      check($sformatf("all.gnt%0d", i), 32'(gnt), 32'(1 << i));
      check($sformatf("all.valid_drop%0d", i), 32'(out_valid), 32'd0);
      req[i] = 1'b0;
      tick();
      check("all.gnt_gap", 32'(gnt), 32'd0);
      check_out($sformatf("all.res%0d", i), 1'b1, i, (i + 1) * (i + 1));
    end
    tick();
    check("all.idle", 32'(busy), 32'd0);

    // Pointer wrapped to 0: requesters 0 and 3 pending, 0 wins, then 3
    req = 4'b1001;
    num_in = 16'h5002;
    tick();
    check("wrap.gnt0", 32'(gnt), 32'h1);
    req = 4'b1000;
    tick();
    check_out("wrap.res0", 1'b1, 0, 4);
    tick();
    check("wrap.gnt3", 32'(gnt), 32'h8);
    req = '0;
    tick();
    check_out("wrap.res3", 1'b1, 3, 25);
    tick();
    check("wrap.idle", 32'(busy), 32'd0);

    // Fairness: grant 0 once (p -> 1), then 0 continuous plus 2 once
    req = 4'b0001;
    num_in = 16'h0603;
    tick();
    check("fair.gnt0", 32'(gnt), 32'h1);
    req = 4'b0101;
    tick();
    check_out("fair.res0", 1'b1, 0, 9);
    tick();
    check("fair.gnt2", 32'(gnt), 32'h4);
    req = 4'b0001;
    tick();
    check_out("fair.res2", 1'b1, 2, 36);
    tick();
    check("fair.gnt0b", 32'(gnt), 32'h1);
    req = '0;
    tick();
    check_out("fair.res0b", 1'b1, 0, 9);
    tick();
    check("fair.idle", 32'(busy), 32'd0);

    // Backpressure: p=1, operand 7 on requester 1, req held while out_ready low
    req = 4'b0010;
    num_in = 16'h0070;
    out_ready = 1'b0;
    tick();
    check("bp.gnt", 32'(gnt), 32'h2);
    tick();
    check_out("bp.res", 1'b1, 1, 49);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp.hold_gnt%0d", i), 32'(gnt), 32'd0);
      check_out($sformatf("bp.hold%0d", i), 1'b1, 1, 49);
    end
    out_ready = 1'b1;
    num_in = 16'h0020;
    tick();
    check("bp.gnt_handshake", 32'(gnt), 32'h2);
    check("bp.valid_drop", 32'(out_valid), 32'd0);
    req = '0;
    tick();
    check_out("bp.res2", 1'b1, 1, 4);
    tick();
    check("bp.idle", 32'(busy), 32'd0);

    // Reset in CALC (p=2 before it)
    req = 4'b0100;
    num_in = 16'h0500;
    tick();
    check("rcalc.gnt", 32'(gnt), 32'h4);
    req = '0;
    pulse_reset("rcalc");
    tick();
    check("rcalc.no_stale", 32'(out_valid), 32'd0);
    check("rcalc.busy", 32'(busy), 32'd0);

    // p=0 after reset: 1 wins over 3; then reset in DONE
    req = 4'b1010;
    num_in = 16'h0030;
    tick();
    check("rdone.gnt", 32'(gnt), 32'h2);
    req = '0;
    out_ready = 1'b0;
    tick();
    check_out("rdone.res", 1'b1, 1, 9);
    pulse_reset("rdone");
    tick();
    check("rdone.no_stale", 32'(out_valid), 32'd0);
    req = 4'b1010;
    out_ready = 1'b1;
    tick();
    check("rdone.p0_gnt", 32'(gnt), 32'h2);
    req = '0;
    tick();
    check_out("rdone.res2", 1'b1, 1, 9);
    tick();

    // Withdrawn request between edges: no grant
    req = 4'b0001;
    #3 req = '0;
    tick();
    check("withdraw.gnt", 32'(gnt), 32'd0);
    check("withdraw.busy", 32'(busy), 32'd0);

    // Operand 0 on requester 2 (p=2)
    req = 4'b0100;
    num_in = 16'h0000;
    tick();
    check("zero.gnt", 32'(gnt), 32'h4);
    req = '0;
    tick();
    check_out("zero.res", 1'b1, 2, 0);
    tick();

    // Operand F on requester 3 (p=3)
    req = 4'b1000;
    num_in = 16'hF000;
    tick();
    check("max.gnt", 32'(gnt), 32'h8);
    req = '0;
    tick();
    check_out("max.res", 1'b1, 3, 225);
    tick();
    check("max.idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/square_share_arbiter.md
# square_share_arbiter

Round-robin controller that shares one unsigned squaring datapath (result = operand × operand) between NREQ requesters. It accepts one request at a time through a request/grant handshake and latches the winner's operand. It computes the square into a registered result and presents it with the winner's ID on a valid/ready output port. It sits between the operand producers and the single shared squaring resource, so the resource is never replicated per requester.

## Interface
- SIZE, 4, operand width in bits; result width is 2*SIZE.
- NREQ, 4, number of requesters (2..16).
- ID_W, 2, requester ID width; must satisfy 2^ID_W >= NREQ.

- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester request; bit i high = requester i has an operand ready.
- num_in  input  NREQ*SIZE  packed operands; requester i occupies bits [i*SIZE +: SIZE].
- gnt  output  NREQ  registered one-hot grant pulse, one cycle, marks the operand as captured.
- busy  output  1  high whenever the FSM is not in IDLE.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result when high together with out_valid.
- out_id  output  ID_W  index of the requester that owns out_sq.
- out_sq  output  2*SIZE  unsigned square of the captured operand.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE, req == 0: stay in IDLE, gnt = 0.
- IDLE, req != 0: pick winner w by round-robin, latch num_in[w] and w, set gnt = 1<<w for one cycle, go to CALC.
- CALC: register out_sq = op*op at full 2*SIZE width, with no truncation or overflow; register out_id = w; set out_valid = 1; go to DONE. This state lasts exactly one cycle.
- DONE: hold out_valid, out_sq and out_id stable until out_valid && out_ready is sampled at an edge.
- On that handshake edge:
  - If req != 0, grant the next winner directly and go to CALC (back-to-back mode, no IDLE cycle). out_valid drops.
  - Otherwise go to IDLE and drop out_valid.
- Round-robin rule:
  - Pointer p starts at 0.
  - The search order is p, p+1, …, NREQ-1, 0, …, p-1, and the first requester with req high wins.
  - After a grant to w, p = w+1 (mod NREQ).
  - The pointer changes only on a grant.
- Requester rule:
  - Hold req and the operand stable until gnt[i] is seen.
  - Drop req, or present a new operand, in the cycle gnt[i] is high. This is always safe because the next sampling edge is in CALC, where req is ignored.
- A request withdrawn before it is granted is legal and is simply not served.
- req and num_in are ignored in CALC and in DONE without a handshake.
- out_sq and out_id keep their last value after out_valid drops.

## Timing
- Reset (asynchronous assert, release synchronous to clk):
  - State goes to IDLE and p = 0.
  - gnt = 0, busy = 0, out_valid = 0, out_id = 0, out_sq = 0.
- Reset mid-operation discards the captured operand and any pending result. No gnt or out_valid is produced for it.
- Latency: with req sampled at edge E0, gnt is high in cycle E0→E1 and out_valid rises after E1. The result is available one cycle after the grant.
- Minimum per-result throughput is 2 cycles in back-to-back mode with out_ready held high, and 3 cycles when going through IDLE.
- gnt is never asserted on two bits and is never asserted in consecutive cycles.
- A new gnt may coincide with the edge that drops out_valid.
- busy is high in CALC and DONE and low only in IDLE.

## Test plan
- Single request: SIZE=4, req=0001, num_in[0]=4'hF.
  - Required: gnt=0001 for one cycle; next cycle out_valid=1, out_id=0, out_sq=8'hE1 (225).
  - With out_ready=1, out_valid drops and the FSM returns to IDLE.
- All four request simultaneously with operands 1,2,3,4 and out_ready=1.
  - Required: grants in order 0,1,2,3, each 2 cycles apart (back-to-back).
  - Results 1,4,9,16 with matching out_id.
  - p wraps to 0 afterwards.
- Fairness: requester 0 requests continuously, requester 2 requests once, and p is at 1.
  - Required: requester 2 is served before requester 0.
  - Requester 0 is never granted twice in a row while requester 2 is pending.
- Backpressure: out_ready=0 for 5 cycles with a result pending (operand 7) while req=0010 is held.
  - Required: out_valid, out_sq=49 and out_id are stable, and no gnt is issued.
  - When out_ready rises, the handshake completes and gnt=0010 is issued at that same edge.
- Reset mid-operation: assert rst_n=0 in CALC and in DONE.
  - Required: all outputs are 0 immediately and no stale result appears after release.
  - The first request after reset is arbitrated with p=0.
- Withdrawn request and edge operands:
  - req pulse dropped before it is sampled → no gnt.
  - Operand 0 → out_sq=0.
  - Operand 4'hF with SIZE=4 → 225 with no truncation.
